// File: rtl/bf8_pkg.sv
// rtl/bf8_pkg.sv - shared constants and state type for the BrainForge8 DMA engine
package bf8_pkg;

    localparam logic [2:0] CFG_SRC_L  = 3'd0;
    localparam logic [2:0] CFG_SRC_H  = 3'd1;
    localparam logic [2:0] CFG_DST_L  = 3'd2;
    localparam logic [2:0] CFG_DST_H  = 3'd3;
    localparam logic [2:0] CFG_LEN_L  = 3'd4;
    localparam logic [2:0] CFG_LEN_H  = 3'd5;
    localparam logic [2:0] CFG_CTRL   = 3'd6;
    localparam logic [2:0] CFG_STATUS = 3'd7;

    localparam int CTRL_START   = 0;
    localparam int CTRL_SRC_INC = 1;
    localparam int CTRL_DST_INC = 2;
    localparam int CTRL_ABORT   = 3;
    localparam int CTRL_FILL    = 4;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ABORTED = 2;

    localparam logic BUS_RW_READ  = 1'b1;
    localparam logic BUS_RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } dma_state_t;

endpackage

// File: rtl/dma_cfg_regs.sv
// rtl/dma_cfg_regs.sv - DMA register window: write decode, CTRL bits, START/ABORT pulses, readback
// Optional fill mode is compiled in with BF8_DMA_FILL_EN.
module dma_cfg_regs
    import bf8_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        busy,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [4:0]  ctrl_wdata,
    output logic [7:0]  cfg_rdata,
    input  logic [15:0] src,
    input  logic [15:0] dst,
    input  logic [15:0] len,
    input  logic        done,
    input  logic        aborted,
    output logic [5:0]  byte_we,
    output logic        start,
    output logic        abort,
    output logic        status_clr,
    output logic        src_inc,
    output logic        dst_inc,
    output logic        fill
);

    logic       wr_ok;
    logic       ctrl_wr;
    logic [7:0] addr_sel;
    logic       fill_q;

    // Everything except ABORT is locked out while a transfer runs.
    assign wr_ok      = cfg_we && !busy;
    assign ctrl_wr    = cfg_we && (cfg_addr == CFG_CTRL);
    assign addr_sel   = 8'b1 << cfg_addr;
    assign byte_we    = wr_ok ? addr_sel[5:0] : 6'b0;
    assign start      = wr_ok && ctrl_wr && ctrl_wdata[CTRL_START];
    assign abort      = busy && ctrl_wr && ctrl_wdata[CTRL_ABORT];
    assign status_clr = wr_ok && (cfg_addr == CFG_STATUS);

`ifdef BF8_DMA_FILL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= 1'b0;
        end else if (wr_ok && ctrl_wr) begin
            fill_q <= ctrl_wdata[CTRL_FILL];
        end
    end
`else
    logic unused_fill_bit;
    assign unused_fill_bit = ctrl_wdata[CTRL_FILL];
    assign fill_q = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_inc <= 1'b0;
            dst_inc <= 1'b0;
        end else if (wr_ok && ctrl_wr) begin
            src_inc <= ctrl_wdata[CTRL_SRC_INC];
            dst_inc <= ctrl_wdata[CTRL_DST_INC];
        end
    end

    assign fill = fill_q;

    always_comb begin
        cfg_rdata = 8'h00;
        case (cfg_addr)
            CFG_SRC_L:  cfg_rdata = src[7:0];
            CFG_SRC_H:  cfg_rdata = src[15:8];
            CFG_DST_L:  cfg_rdata = dst[7:0];
            CFG_DST_H:  cfg_rdata = dst[15:8];
            CFG_LEN_L:  cfg_rdata = len[7:0];
            CFG_LEN_H:  cfg_rdata = len[15:8];
            CFG_CTRL: begin
                cfg_rdata[CTRL_SRC_INC] = src_inc;
                cfg_rdata[CTRL_DST_INC] = dst_inc;
                cfg_rdata[CTRL_FILL]    = fill_q;
            end
            default: begin
                cfg_rdata[STAT_BUSY]    = busy;
                cfg_rdata[STAT_DONE]    = done;
                cfg_rdata[STAT_ABORTED] = aborted;
            end
        endcase
    end

endmodule

// File: rtl/dma_engine.sv
// rtl/dma_engine.sv - single-channel memory-to-memory DMA: transfer FSM, address/length counters, bus master
module dma_engine
    import bf8_pkg::*;
#(
    parameter logic [15:0] RST_SRC = 16'h0000,
    parameter logic [15:0] RST_DST = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [7:0]  cfg_wdata,
    output logic [7:0]  cfg_rdata,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_data,
    output logic        bus_rw,
    output logic        bus_rq,
    input  logic        bus_ok,
    input  logic [7:0]  bus_rdata,
    output logic        done
);

    dma_state_t  state, state_n;
    logic [15:0] src, src_n, dst, dst_n, len, len_n;
    logic [15:0] addr_n;
    logic [7:0]  data_n;
    logic        rq_n, rw_n, done_n;
    logic        aborted, aborted_n;
    logic        abort_pend, pend_n;
    logic        rd_fresh, rd_fresh_n;
    logic [15:0] src_step, dst_step, len_dec;

    logic [5:0]  byte_we;
    logic        start, abort, status_clr, src_inc, dst_inc, fill, busy;

    assign busy = (state != IDLE);

    dma_cfg_regs u_cfg_regs (
        .clk        (clk),
        .rst_n      (rst_n),
        .busy       (busy),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .ctrl_wdata (cfg_wdata[4:0]),
        .cfg_rdata  (cfg_rdata),
        .src        (src),
        .dst        (dst),
        .len        (len),
        .done       (done),
        .aborted    (aborted),
        .byte_we    (byte_we),
        .start      (start),
        .abort      (abort),
        .status_clr (status_clr),
        .src_inc    (src_inc),
        .dst_inc    (dst_inc),
        .fill       (fill)
    );

    // Fill mode writes a constant, so the source pointer must not move.
    assign src_step = src + {15'b0, src_inc & ~fill};
    assign dst_step = dst + {15'b0, dst_inc};
    assign len_dec  = len - 16'd1;

    always_comb begin
        state_n   = state;
        src_n     = src;
        dst_n     = dst;
        len_n     = len;
        addr_n    = bus_addr;
        data_n    = bus_data;
        rq_n      = bus_rq;
        rw_n      = bus_rw;
        done_n    = done;
        aborted_n = aborted;
        pend_n    = abort_pend | abort;

        if (byte_we[CFG_SRC_L]) src_n[7:0]  = cfg_wdata;
        if (byte_we[CFG_SRC_H]) src_n[15:8] = cfg_wdata;
        if (byte_we[CFG_DST_L]) dst_n[7:0]  = cfg_wdata;
        if (byte_we[CFG_DST_H]) dst_n[15:8] = cfg_wdata;
        if (byte_we[CFG_LEN_L]) len_n[7:0]  = cfg_wdata;
        if (byte_we[CFG_LEN_H]) len_n[15:8] = cfg_wdata;
        if (status_clr) begin
            done_n    = 1'b0;
            aborted_n = 1'b0;
        end

        case (state)
            IDLE: begin
                pend_n = 1'b0;
                if (start) begin
                    if (len == 16'd0) begin
                        done_n = 1'b1;
                    end else if (fill) begin
                        state_n = WR;
                        rq_n    = 1'b1;
                        rw_n    = BUS_RW_WRITE;
                        addr_n  = dst;
                        data_n  = src[7:0];
                    end else begin
                        state_n = RD;
                        rq_n    = 1'b1;
                        rw_n    = BUS_RW_READ;
                        addr_n  = src;
                    end
                end
            end
            RD: begin
                // An abort already pending on the first request edge cancels the read outright.
                if (rd_fresh && abort_pend) begin
                    state_n   = FIN;
                    rq_n      = 1'b0;
                    done_n    = 1'b1;
                    aborted_n = 1'b1;
                end else if (bus_ok) begin
                    state_n = WR;
                    data_n  = bus_rdata;
                    rw_n    = BUS_RW_WRITE;
                    addr_n  = dst;
                end
            end
            WR: begin
                if (bus_ok) begin
                    src_n = src_step;
                    dst_n = dst_step;
                    len_n = len_dec;
                    if (len_dec == 16'd0 || abort_pend) begin
                        state_n   = FIN;
                        rq_n      = 1'b0;
                        rw_n      = BUS_RW_READ;
                        done_n    = 1'b1;
                        aborted_n = abort_pend;
                    end else if (fill) begin
                        addr_n = dst_step;
                    end else begin
                        state_n = RD;
                        rw_n    = BUS_RW_READ;
                        addr_n  = src_step;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                rq_n    = 1'b0;
                pend_n  = 1'b0;
            end
        endcase

        rd_fresh_n = (state_n == RD) && (state != RD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            src        <= RST_SRC;
            dst        <= RST_DST;
            len        <= 16'd0;
            bus_addr   <= 16'd0;
            bus_data   <= 8'd0;
            bus_rq     <= 1'b0;
            bus_rw     <= BUS_RW_READ;
            done       <= 1'b0;
            aborted    <= 1'b0;
            abort_pend <= 1'b0;
            rd_fresh   <= 1'b0;
        end else begin
            state      <= state_n;
            src        <= src_n;
            dst        <= dst_n;
            len        <= len_n;
            bus_addr   <= addr_n;
            bus_data   <= data_n;
            bus_rq     <= rq_n;
            bus_rw     <= rw_n;
            done       <= done_n;
            aborted    <= aborted_n;
            abort_pend <= pend_n;
            rd_fresh   <= rd_fresh_n;
        end
    end

endmodule

// File: tb/tb_dma_engine.sv
// tb/tb_dma_engine.sv - directed self-checking bench for dma_engine with a stalling bus memory model
module tb_dma_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = 3'd0;
    logic [7:0]  cfg_wdata = 8'd0;
    logic [7:0]  cfg_rdata;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data;
    logic        bus_rw;
    logic        bus_rq;
    logic        bus_ok;
    logic [7:0]  bus_rdata;
    logic        done;

    int checks = 0;
    int fails  = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] log_addr [0:63];
    logic        log_rw   [0:63];
    int          log_cnt = 0;
    int          stall_cfg = 0;
    int          stall_cnt = 0;
    int          stab_err = 0;
    logic        have_prev = 1'b0;
    logic [15:0] p_addr;
    logic [7:0]  p_data;
    logic        p_rw;

    always #5 clk = ~clk;

    dma_engine #(.RST_SRC(16'hA55A), .RST_DST(16'h0F0F)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .bus_addr(bus_addr),
        .bus_data(bus_data), .bus_rw(bus_rw), .bus_rq(bus_rq), .bus_ok(bus_ok),
        .bus_rdata(bus_rdata), .done(done)
    );

    assign bus_ok    = bus_rq && (stall_cnt >= stall_cfg);
    assign bus_rdata = mem[bus_addr];

    always @(posedge clk) begin
        if (bus_rq) begin
            if (bus_ok) begin
                if (log_cnt < 64) begin
                    log_addr[log_cnt] <= bus_addr;
                    log_rw[log_cnt]   <= bus_rw;
                end
                log_cnt <= log_cnt + 1;
                if (!bus_rw) mem[bus_addr] <= bus_data;
                stall_cnt <= 0;
                have_prev <= 1'b0;
            end else begin
                if (have_prev && (bus_addr !== p_addr || bus_rw !== p_rw || bus_data !== p_data))
                    stab_err <= stab_err + 1;
                p_addr    <= bus_addr;
                p_rw      <= bus_rw;
                p_data    <= bus_data;
                have_prev <= 1'b1;
                stall_cnt <= stall_cnt + 1;
            end
        end else begin
            stall_cnt <= 0;
            have_prev <= 1'b0;
        end
    end

    task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic cfg_read(input logic [2:0] a, output logic [7:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    task automatic program_regs(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
        cfg_write(3'd0, s[7:0]);  cfg_write(3'd1, s[15:8]);
        cfg_write(3'd2, d[7:0]);  cfg_write(3'd3, d[15:8]);
        cfg_write(3'd4, l[7:0]);  cfg_write(3'd5, l[15:8]);
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        logic [7:0] r;
        logic [7:0] exp_rst [0:7];
        exp_rst = '{8'h5A, 8'hA5, 8'h0F, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00};
        checks++; if ({bus_rq, bus_rw, bus_addr, bus_data, done} !== {1'b0, 1'b1, 16'h0, 8'h0, 1'b0}) begin
            fails++; $display("FAIL reset_bus: got rq=%b rw=%b addr=%h data=%h done=%b want 0 1 0000 00 0",
                              bus_rq, bus_rw, bus_addr, bus_data, done); end
        for (int i = 0; i < 8; i++) begin
            cfg_read(3'(i), r);
            checks++; if (r !== exp_rst[i]) begin
                fails++; $display("FAIL reset_reg%0d: got %h want %h", i, r, exp_rst[i]); end
        end
    endtask

    task automatic test_copy(input int stall, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        int cyc;
        logic [7:0] r;
        logic [7:0] exp_b [0:2];
        exp_b = '{b0, b1, b2};
        stall_cfg = stall;
        for (int i = 0; i < 3; i++) begin mem[16'h1000 + i] = exp_b[i]; mem[16'h2000 + i] = 8'h00; end
        program_regs(16'h1000, 16'h2000, 16'd3);
        log_cnt = 0;
        cfg_write(3'd6, 8'h07);
        wait_done(200, cyc);
        checks++; if (cyc !== 6 * (stall + 1)) begin
            fails++; $display("FAIL copy_cycles stall=%0d: got %0d want %0d", stall, cyc, 6 * (stall + 1)); end
        checks++; if (log_cnt !== 6) begin
            fails++; $display("FAIL copy_accesses stall=%0d: got %0d want 6", stall, log_cnt); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (log_addr[i] !== ((i % 2) ? 16'h2000 : 16'h1000) + 16'(i / 2) || log_rw[i] !== (i % 2 == 0)) begin
                fails++; $display("FAIL copy_seq%0d: got addr=%h rw=%b", i, log_addr[i], log_rw[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem[16'h2000 + i] !== exp_b[i]) begin
                fails++; $display("FAIL copy_data%0d: got %h want %h", i, mem[16'h2000 + i], exp_b[i]); end
        end
        checks++; if (stab_err !== 0) begin
            fails++; $display("FAIL copy_stable: got %0d changes during stall want 0", stab_err); end
        @(negedge clk);
        cfg_read(3'd7, r);
        checks++; if (r !== 8'h02) begin fails++; $display("FAIL copy_status: got %h want 02", r); end
        cfg_read(3'd0, r);
        checks++; if (r !== 8'h03) begin fails++; $display("FAIL copy_src_l: got %h want 03", r); end
        cfg_read(3'd4, r);
        checks++; if (r !== 8'h00) begin fails++; $display("FAIL copy_len_l: got %h want 00", r); end
        cfg_write(3'd7, 8'h00);
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL copy_clear: got done=%b want 0", done); end
        stall_cfg = 0;
    endtask

    task automatic test_wrap;
        int cyc;
        logic [7:0] r;
        mem[16'hFFFF] = 8'h11; mem[16'h0000] = 8'h22; mem[16'h0010] = 8'h00;
        program_regs(16'hFFFF, 16'h0010, 16'd2);
        log_cnt = 0;
        cfg_write(3'd6, 8'h03);
        wait_done(50, cyc);
        checks++; if (log_cnt !== 4 || log_addr[0] !== 16'hFFFF || log_addr[1] !== 16'h0010 ||
                      log_addr[2] !== 16'h0000 || log_addr[3] !== 16'h0010) begin
            fails++; $display("FAIL wrap_seq: got n=%0d %h %h %h %h want 4 ffff 0010 0000 0010",
                              log_cnt, log_addr[0], log_addr[1], log_addr[2], log_addr[3]); end
        checks++; if (mem[16'h0010] !== 8'h22) begin fails++; $display("FAIL wrap_data: got %h want 22", mem[16'h0010]); end
        @(negedge clk);
        cfg_read(3'd1, r);
        checks++; if (r !== 8'h00) begin fails++; $display("FAIL wrap_src_h: got %h want 00", r); end
        cfg_read(3'd0, r);
        checks++; if (r !== 8'h01) begin fails++; $display("FAIL wrap_src_l: got %h want 01", r); end
        cfg_read(3'd2, r);
        checks++; if (r !== 8'h10) begin fails++; $display("FAIL wrap_dst_l: got %h want 10", r); end
        cfg_write(3'd7, 8'h00);
    endtask

    task automatic test_zero_len;
        logic [7:0] r;
        program_regs(16'h1000, 16'h2000, 16'd0);
        log_cnt = 0;
        cfg_write(3'd6, 8'h07);
        checks++; if (done !== 1'b1) begin fails++; $display("FAIL zero_done: got %b want 1", done); end
        repeat (5) @(negedge clk);
        checks++; if (log_cnt !== 0 || bus_rq !== 1'b0) begin
            fails++; $display("FAIL zero_nobus: got accesses=%0d rq=%b want 0 0", log_cnt, bus_rq); end
        cfg_read(3'd7, r);
        checks++; if (r !== 8'h02) begin fails++; $display("FAIL zero_status: got %h want 02", r); end
        cfg_write(3'd7, 8'hFF);
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL zero_clear: got %b want 0", done); end
    endtask

    task automatic test_abort;
        int cyc;
        logic [7:0] r;
        cfg_write(3'd6, 8'h08);
        cfg_read(3'd7, r);
        checks++; if (r !== 8'h00) begin fails++; $display("FAIL abort_idle: got %h want 00", r); end
        for (int i = 0; i < 10; i++) mem[16'h3000 + i] = 8'(8'h40 + i);
        stall_cfg = 4;
        program_regs(16'h3000, 16'h4000, 16'd10);
        log_cnt = 0;
        cfg_write(3'd6, 8'h07);
        cyc = 0;
        while (log_cnt < 4 && cyc < 200) begin @(negedge clk); cyc++; end
        checks++; if (log_cnt !== 4) begin fails++; $display("FAIL abort_reach: got %0d accesses want 4", log_cnt); end
        repeat (2) @(negedge clk);
        cfg_write(3'd6, 8'h08);
        wait_done(100, cyc);
        repeat (20) @(negedge clk);
        checks++; if (log_cnt !== 6) begin fails++; $display("FAIL abort_accesses: got %0d want 6", log_cnt); end
        checks++; if (mem[16'h4002] !== 8'h42) begin fails++; $display("FAIL abort_byte3: got %h want 42", mem[16'h4002]); end
        cfg_read(3'd7, r);
        checks++; if (r !== 8'h06) begin fails++; $display("FAIL abort_status: got %h want 06", r); end
        cfg_read(3'd4, r);
        checks++; if (r !== 8'h07) begin fails++; $display("FAIL abort_len: got %h want 07", r); end
        cfg_write(3'd7, 8'h00);
        cfg_read(3'd7, r);
        checks++; if (r !== 8'h00) begin fails++; $display("FAIL abort_clear: got %h want 00", r); end
        stall_cfg = 0;
    endtask

    task automatic test_reset_mid;
        int cyc;
        logic [7:0] r;
        stall_cfg = 4;
        program_regs(16'h5000, 16'h6000, 16'd5);
        cfg_write(3'd6, 8'h07);
        cyc = 0;
        while (!(bus_rq && !bus_rw) && cyc < 100) begin @(negedge clk); cyc++; end
        checks++; if (!(bus_rq === 1'b1 && bus_rw === 1'b0)) begin
            fails++; $display("FAIL rstmid_reach: got rq=%b rw=%b want 1 0", bus_rq, bus_rw); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({bus_rq, bus_rw, bus_addr, bus_data, done} !== {1'b0, 1'b1, 16'h0, 8'h0, 1'b0}) begin
            fails++; $display("FAIL rstmid_bus: got rq=%b rw=%b addr=%h data=%h done=%b want 0 1 0000 00 0",
                              bus_rq, bus_rw, bus_addr, bus_data, done); end
        cfg_read(3'd0, r);
        checks++; if (r !== 8'h5A) begin fails++; $display("FAIL rstmid_src: got %h want 5a", r); end
        cfg_read(3'd4, r);
        checks++; if (r !== 8'h00) begin fails++; $display("FAIL rstmid_len: got %h want 00", r); end
        cfg_read(3'd6, r);
        checks++; if (r !== 8'h00) begin fails++; $display("FAIL rstmid_ctrl: got %h want 00", r); end
        cfg_read(3'd7, r);
        checks++; if (r !== 8'h00) begin fails++; $display("FAIL rstmid_status: got %h want 00", r); end
        @(negedge clk);
        rst_n = 1'b1;
        stall_cfg = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_copy(0, 8'hA1, 8'hB2, 8'hC3);
        test_copy(4, 8'h5A, 8'h6B, 8'h7C);
        test_wrap;
        test_zero_len;
        test_abort;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
